i2s_rx_core: RTL and testbench
==============================

I2S_RX_CORE -- requirements
Module: i2s_rx_core

Interface
REQ-001 SHALL have parameter DW, default 24: received sample width in bits per channel.
REQ-002 SHALL have parameter SLOT, default 32: SCLK periods per channel slot (SCLK = 2*SLOT*LRCLK); DW <= SLOT-1.
REQ-003 SHALL have port FCLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SCLK  input  1  I2S bit clock, asynchronous to FCLK.
REQ-006 SHALL have port LRCLK  input  1  I2S word select, 0 = left, 1 = right, asynchronous.
REQ-007 SHALL have port SDIN  input  1  I2S serial data, MSB first, asynchronous.
REQ-008 SHALL have port outReady  input  1  consumer accepts frame when high with outValid.
REQ-009 SHALL have port outValid  output  1  outL/outR hold a complete stereo frame.
REQ-010 SHALL have port outL  output  DW  left sample, raw two's complement.
REQ-011 SHALL have port outR  output  DW  right sample, raw two's complement.
REQ-012 SHALL have port overrun  output  1  one-FCLK pulse when a frame is dropped.
REQ-013 SHALL have port frameErr  output  1  one-FCLK pulse on a short slot.

Function
REQ-014 SHALL pass SCLK, LRCLK and SDIN each through a 2-flop FCLK synchronizer; FCLK >= 4*SCLK is required.
REQ-015 SHALL form sclkRise as a one-cycle strobe on a synchronized SCLK 0->1 transition; all LRCLK/SDIN sampling occurs only on sclkRise.
REQ-016 SHALL detect a word-select change when the LRCLK sampled at sclkRise differs from the previous sampled value; the bit counter then resets to 0.
REQ-017 SHALL, per I2S one-bit delay, treat the bit at counter k (1..DW) as bit DW-k of the current channel; bits at k=0 and k>DW are ignored; counter saturates at SLOT.
REQ-018 SHALL implement FSM HUNT, LEFT, RIGHT; HUNT->LEFT on LRCLK 1->0; LEFT->RIGHT on 0->1 (left shift register copied to holdL); RIGHT->LEFT on 1->0 (frame complete).
REQ-019 SHALL discard any data received in HUNT, so a stream starting mid-frame yields no output until one full LEFT+RIGHT pair completes.
REQ-020 SHALL, on frame complete, load outL<=holdL, outR<=right shift register and assert outValid on the FCLK cycle after the detecting sclkRise.
REQ-021 SHALL hold outValid, outL, outR stable until outValid&&outReady; outValid then drops next cycle unless a new frame completes.
REQ-022 SHALL, if a frame completes while outValid&&!outReady, drop the new frame, keep old outputs, pulse overrun.
REQ-023 SHALL, if a frame completes in the same cycle as outValid&&outReady, load the new frame, keep outValid=1, no overrun.
REQ-024 SHALL, if a slot ends (word-select change) with counter < DW, pulse frameErr, discard the partial frame, and enter HUNT (LRCLK 1->0 detection re-arms LEFT).

Reset
REQ-025 SHALL, while Reset=1 at an FCLK edge, clear synchronizers, shift registers, holdL, counter, outL, outR to 0, outValid, overrun, frameErr to 0, FSM to HUNT.
REQ-026 SHALL discard any partial frame on Reset mid-operation; first output only after a fresh LRCLK fall plus full frame.

Configuration
REQ-027 SHALL, with macro I2S_RX_OVERRUN_CNT_EN defined, add output overrunCnt[7:0] incrementing on each overrun pulse, saturating at 255, cleared only by Reset.
REQ-028 SHALL, without I2S_RX_OVERRUN_CNT_EN, omit the overrunCnt port and counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: DW=24, SLOT=32, left 0x123456, right 0xABCDEF, outReady=1 -> outValid pulse after next LRCLK fall, outL=0x123456, outR=0xABCDEF.
REQ-030 SHALL cover: stream starting mid-right slot -> no outValid until first complete left/right pair, then correct values.
REQ-031 SHALL cover: outReady=0 over two frames (0x000001/0x000002, then 0x000003/0x000004) -> outputs stay 0x000001/0x000002, one overrun pulse, overrunCnt=1 with macro.
REQ-032 SHALL cover: 16-SCLK left slot -> frameErr pulse, no outValid, next normal frame received correctly.
REQ-033 SHALL cover: Reset asserted mid-left slot -> outValid=0 and outputs 0 next cycle; no frame until after fresh LRCLK fall.
REQ-034 SHALL cover: 300 overruns with macro -> overrunCnt saturates at 255.

Source files
------------

// File: rtl/i2s_rx_core.sv
// I2S receiver: synchronizes SCLK/LRCLK/SDIN into FCLK, deserializes stereo frames
// and presents them on a valid/ready output. Define I2S_RX_OVERRUN_CNT_EN to add overrunCnt.
module i2s_rx_core #(
  parameter int DW   = 24,
  parameter int SLOT = 32
) (
  input  logic          FCLK,
  input  logic          Reset,
  input  logic          SCLK,
  input  logic          LRCLK,
  input  logic          SDIN,
  input  logic          outReady,
  output logic          outValid,
  output logic [DW-1:0] outL,
  output logic [DW-1:0] outR,
  output logic          overrun,
  output logic          frameErr
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  output logic [7:0]    overrunCnt
`endif
);

  localparam int CW = $clog2(SLOT + 1);
  localparam logic [CW-1:0] DW_C   = CW'(DW);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} StateT;

  StateT         state, stateNext;
  logic [1:0]    sclkSync, lrSync, sdSync;
  logic          sclkPrev, lrPrev;
  logic          sclkRise, wsChange;
  logic [CW-1:0] bitCnt, bitCntNext;
  logic [DW-1:0] shiftReg, holdL;
  logic          holdLoad, frameDone, slotErr;

  // Two-flop synchronizers plus a delayed SCLK copy for rising-edge detection
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      sclkSync <= '0;
      lrSync   <= '0;
      sdSync   <= '0;
      sclkPrev <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[0], SCLK};
      lrSync   <= {lrSync[0], LRCLK};
      sdSync   <= {sdSync[0], SDIN};
      sclkPrev <= sclkSync[1];
    end
  end

  assign sclkRise = sclkSync[1] & ~sclkPrev;
  assign wsChange = sclkRise && (lrSync[1] != lrPrev);

  always_comb begin
    bitCntNext = bitCnt;
    if (wsChange)
      bitCntNext = '0;
    else if (bitCnt != SLOT_C)
      bitCntNext = bitCnt + CW'(1);
  end

  // Bit position 0 is the previous word's trailing bit; positions 1..DW carry MSB..LSB
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      lrPrev   <= 1'b0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else if (sclkRise) begin
      lrPrev <= lrSync[1];
      bitCnt <= bitCntNext;
      if (bitCntNext != '0 && bitCntNext <= DW_C)
        shiftReg <= (shiftReg << 1) | DW'(sdSync[1]);
    end
  end

  always_ff @(posedge FCLK) begin
    if (Reset)
      state <= HUNT;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    holdLoad  = 1'b0;
    frameDone = 1'b0;
    slotErr   = 1'b0;
    if (wsChange) begin
      case (state)
        HUNT: begin
          if (!lrSync[1])
            stateNext = LEFT;
        end
        LEFT: begin
          if (bitCnt < DW_C) begin
            slotErr   = 1'b1;
            stateNext = HUNT;
          end else begin
            holdLoad  = 1'b1;
            stateNext = RIGHT;
          end
        end
        RIGHT: begin
          if (bitCnt < DW_C) begin
            slotErr   = 1'b1;
            stateNext = HUNT;
          end else begin
            frameDone = 1'b1;
            stateNext = LEFT;
          end
        end
        default: stateNext = HUNT;
      endcase
    end
  end

  always_ff @(posedge FCLK) begin
    if (Reset)
      holdL <= '0;
    else if (holdLoad)
      holdL <= shiftReg;
  end

  // A completed frame replaces the output only if the slot is empty or being consumed now
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      outValid <= 1'b0;
      outL     <= '0;
      outR     <= '0;
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      frameErr <= slotErr;
      if (frameDone) begin
        if (!outValid || outReady) begin
          outL     <= holdL;
          outR     <= shiftReg;
          outValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_ff @(posedge FCLK) begin
    if (Reset)
      overrunCnt <= '0;
    else if (overrun && overrunCnt != 8'hFF)
      overrunCnt <= overrunCnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_core.sv
// Scoreboard bench for i2s_rx_core: a slot-level I2S transmitter model predicts frames,
// overruns and frame errors; a monitor compares on every output handshake.
module tb_i2s_rx_core;

  localparam int DW   = 24;
  localparam int SLOT = 32;
  localparam int HALF = 20;

  logic          FCLK = 1'b0;
  logic          Reset = 1'b1;
  logic          SCLK = 1'b0;
  logic          LRCLK = 1'b0;
  logic          SDIN = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid;
  logic [DW-1:0] outL, outR;
  logic          overrun, frameErr;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [7:0]    overrunCnt;
`endif

  always #5 FCLK = ~FCLK;

  i2s_rx_core #(.DW(DW), .SLOT(SLOT)) dut (
    .FCLK(FCLK), .Reset(Reset), .SCLK(SCLK), .LRCLK(LRCLK), .SDIN(SDIN),
    .outReady(outReady), .outValid(outValid), .outL(outL), .outR(outR),
    .overrun(overrun), .frameErr(frameErr)
`ifdef I2S_RX_OVERRUN_CNT_EN
    , .overrunCnt(overrunCnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } FrameT;

  FrameT         expQ[$];
  int            total = 0, bad = 0;
  int            readyMode = 0;
  int            modelMode = 0;
  logic          modelLr = 1'b0;
  int            slotLen = 0;
  logic [DW-1:0] slotData = '0;
  logic [DW-1:0] modelLeft = '0;
  bit            outstanding = 1'b0;
  int            expOverruns = 0, expFrameErrs = 0, expOvrSinceReset = 0;
  int            seenOverruns = 0, seenFrameErrs = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic frameComplete(input logic [DW-1:0] l, input logic [DW-1:0] r);
    FrameT f;
    if (outstanding) begin
      expOverruns++;
      expOvrSinceReset++;
    end else begin
      f.l = l;
      f.r = r;
      expQ.push_back(f);
      outstanding = 1'b1;
    end
  endtask

  // Evaluate the slot that just ended when the word select changes (mode 0 hunt, 1 left, 2 right)
  task automatic modelBoundary(input logic newLr, input logic [DW-1:0] newData);
    if (newLr == modelLr) return;
    case (modelMode)
      0: if (!newLr) modelMode = 1;
      1: begin
        if (slotLen - 1 < DW) begin
          expFrameErrs++;
          modelMode = 0;
        end else begin
          modelLeft = slotData;
          modelMode = 2;
        end
      end
      default: begin
        if (slotLen - 1 < DW) begin
          expFrameErrs++;
          modelMode = 0;
        end else begin
          frameComplete(modelLeft, slotData);
          modelMode = 1;
        end
      end
    endcase
    modelLr  = newLr;
    slotLen  = 0;
    slotData = newData;
  endtask

  task automatic modelReset();
    expQ.delete();
    outstanding      = 1'b0;
    modelMode        = 0;
    modelLr          = 1'b0;
    slotLen          = 0;
    expOvrSinceReset = 0;
  endtask

  task automatic applyStimulus(input logic lr, input logic [DW-1:0] data, input int len);
    int k;
    modelBoundary(lr, data);
    for (int i = 0; i < len; i++) begin
      k = slotLen;
      SCLK  = 1'b0;
      LRCLK = lr;
      SDIN  = (k >= 1 && k <= DW) ? slotData[DW-k] : 1'($urandom_range(0, 1));
      #HALF;
      SCLK = 1'b1;
      #HALF;
      slotLen++;
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  initial begin
    forever begin
      @(posedge FCLK);
      #2;
      case (readyMode)
        0:       outReady = 1'b0;
        1:       outReady = 1'($urandom_range(0, 1));
        default: outReady = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted frame and tallies status pulses
  always @(negedge FCLK) begin
    if (!Reset) begin
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedFrame: got L=0x%0h R=0x%0h expected none", outL, outR);
        end else begin
          FrameT f;
          f = expQ.pop_front();
          checkOutput("frameL", 32'(outL), 32'(f.l));
          checkOutput("frameR", 32'(outR), 32'(f.r));
        end
        outstanding = 1'b0;
      end
      if (overrun)  seenOverruns++;
      if (frameErr) seenFrameErrs++;
    end
  end

  initial begin
    #3;
    repeat (4) @(posedge FCLK);
    #1;
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetL", 32'(outL), 32'd0);
    checkOutput("resetR", 32'(outR), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    checkOutput("resetFrameErr", 32'(frameErr), 32'd0);
    Reset = 1'b0;

    // Stream begins mid right slot, then the reference frame
    readyMode = 2;
    applyStimulus(1'b1, rnd(), 13);
    applyStimulus(1'b0, 24'h123456, 32);
    applyStimulus(1'b1, 24'hABCDEF, 32);

    readyMode = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, rnd(), 32);
      applyStimulus(1'b1, rnd(), SLOT - $urandom_range(0, 7));
    end

    // Consumer stalls across two frames
    readyMode = 2;
    applyStimulus(1'b0, 24'h000001, 32);
    readyMode = 0;
    applyStimulus(1'b1, 24'h000002, 32);
    applyStimulus(1'b0, 24'h000003, 32);
    applyStimulus(1'b1, 24'h000004, 32);
    applyStimulus(1'b0, rnd(), 32);
    checkOutput("stallValid", 32'(outValid), 32'd1);
    checkOutput("stallL", 32'(outL), 32'h000001);
    checkOutput("stallR", 32'(outR), 32'h000002);
    checkOutput("overrunPulses", 32'(seenOverruns), 32'(expOverruns));
`ifdef I2S_RX_OVERRUN_CNT_EN
    checkOutput("overrunCnt", 32'(overrunCnt), 32'd1);
`endif
    readyMode = 2;
    applyStimulus(1'b1, rnd(), 32);

    // Short left slot
    applyStimulus(1'b0, 24'h555555, 16);
    applyStimulus(1'b1, rnd(), 32);
    checkOutput("frameErrPulses", 32'(seenFrameErrs), 32'(expFrameErrs));
    applyStimulus(1'b0, 24'h0F0F0F, 32);
    applyStimulus(1'b1, 24'hF0F0F0, 32);

    // Reset in the middle of a left slot while a frame is held
    applyStimulus(1'b0, rnd(), 32);
    readyMode = 0;
    applyStimulus(1'b1, rnd(), 32);
    applyStimulus(1'b0, rnd(), 10);
    checkOutput("preResetValid", 32'(outValid), 32'd1);
    @(posedge FCLK);
    #1 Reset = 1'b1;
    @(posedge FCLK);
    #1;
    checkOutput("midResetValid", 32'(outValid), 32'd0);
    checkOutput("midResetL", 32'(outL), 32'd0);
    checkOutput("midResetR", 32'(outR), 32'd0);
    Reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, rnd(), 22);
    readyMode = 2;
    applyStimulus(1'b1, rnd(), 32);
    applyStimulus(1'b0, rnd(), 32);
    applyStimulus(1'b1, rnd(), 32);
    applyStimulus(1'b0, rnd(), 32);

`ifdef I2S_RX_OVERRUN_CNT_EN
    readyMode = 0;
    for (int i = 0; i < 302; i++) begin
      applyStimulus(1'b1, rnd(), 25);
      applyStimulus(1'b0, rnd(), 25);
    end
    checkOutput("overrunCntSat", 32'(overrunCnt),
                32'((expOvrSinceReset > 255) ? 255 : expOvrSinceReset));
    readyMode = 2;
    applyStimulus(1'b1, rnd(), 32);
`endif

    readyMode = 2;
    repeat (50) @(posedge FCLK);
    checkOutput("pendingFrames", 32'(expQ.size()), 32'd0);
    checkOutput("overrunTotal", 32'(seenOverruns), 32'(expOverruns));
    checkOutput("frameErrTotal", 32'(seenFrameErrs), 32'(expFrameErrs));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
